fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the 5-stage pipeline.
- Keeps its own shadow pipeline of in-flight register tags (EX, MEM, WB) fed from ID.
- Drives per-operand EX forwarding selects and the ID-stage load-use stall.
- Supports NUM_SRC source operands, so it serves both the base core and the 3-operand variant.

---
 rtl/fwd_pkg.sv | 41 ++++
 rtl/fwd_src_sel.sv | 52 +++++
 rtl/fwd_hazard_unit.sv | 180 ++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// ----------------------------------------------------------------------------
// fwd_pkg
// Shared types and helpers for the forwarding / load-use hazard unit.
//   FWD_RF / FWD_MEM / FWD_WB : EX operand select encodings
//   stage_tag_t               : in-flight register tag held per pipeline stage
//   isZeroReg()               : true when an address names the hardwired zero reg
//   stageMatch()              : forwarding match term for one stage vs one source
// ----------------------------------------------------------------------------
package fwd_pkg;

    // EX operand select encodings; 2'b11 is never produced.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Tag address width. Register addresses (REG_AW) are zero-extended into this,
    // so REG_AW must not exceed TAG_AW.
    localparam int unsigned TAG_AW = 8;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] dst;
        logic              wr;
        logic              load;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    function automatic logic isZeroReg(input logic [TAG_AW-1:0] addr,
                                       input logic              hardwiredZero);
        return hardwiredZero && (addr == '0);
    endfunction

    function automatic logic stageMatch(input stage_tag_t        tag,
                                        input logic [TAG_AW-1:0] addr,
                                        input logic              hardwiredZero);
        return tag.valid && tag.wr && !isZeroReg(tag.dst, hardwiredZero) &&
               (tag.dst == addr);
    endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// ----------------------------------------------------------------------------
// fwd_src_sel
// Forwarding select for a single EX source operand.
// Ports:
//   srcAddr_i  : source register address held in EX
//   srcUsed_i  : the operand is actually read
//   exValid_i  : EX holds a real instruction
//   memTag_i   : tag of the instruction in MEM
//   wbTag_i    : tag of the instruction in WB
//   sel_o      : FWD_MEM, FWD_WB or FWD_RF
// ----------------------------------------------------------------------------
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned HARDWIRED_ZERO = 1
) (
    input  logic [REG_AW-1:0] srcAddr_i,
    input  logic              srcUsed_i,
    input  logic              exValid_i,
    input  stage_tag_t        memTag_i,
    input  stage_tag_t        wbTag_i,
    output logic [1:0]        sel_o
);

    localparam logic HzBit = (HARDWIRED_ZERO != 0);

    logic [TAG_AW-1:0] srcTag;
    logic              memHit;
    logic              wbHit;

    assign srcTag = TAG_AW'(srcAddr_i);
    assign memHit = stageMatch(memTag_i, srcTag, HzBit);
    assign wbHit  = stageMatch(wbTag_i, srcTag, HzBit);

    // Load flags only matter for the stall path, not for selection.
    logic unusedLoad;
    assign unusedLoad = memTag_i.load ^ wbTag_i.load;

    // MEM is checked first: it holds the younger producer.
    always_comb begin
        sel_o = FWD_RF;
        if (exValid_i && srcUsed_i) begin
            if (memHit) begin
                sel_o = FWD_MEM;
            end else if (wbHit) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and load-use hazard unit for the 5-stage pipeline. Tracks a shadow
// pipeline of register tags (EX, MEM, WB) fed from ID and produces per-operand
// EX forwarding selects plus the ID-stage load-use stall.
//
// Build option: define FWD_PERF_CNT_EN to add saturating 32-bit counters
//   perf_stall_cnt (un-held stall cycles) and perf_fwd_cnt (un-held cycles
//   with any operand forwarded).
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   id_valid        : ID holds a real instruction
//   id_src_addr     : source addresses, operand i at [i*REG_AW +: REG_AW]
//   id_src_used     : operand i is read
//   id_dst_addr     : destination register
//   id_reg_write    : instruction writes the register file
//   id_is_load      : instruction is a load
//   pipe_hold       : global freeze
//   pipe_flush      : squash ID/EX
//   hazard_stall    : hold PC and IF/ID, bubble into ID/EX
//   fwd_sel         : per-operand EX select, operand i at [2i +: 2]
// ----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned HARDWIRED_ZERO = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    input  logic                      pipe_hold,
    input  logic                      pipe_flush,
    output logic                      hazard_stall,
    output logic [NUM_SRC*2-1:0]      fwd_sel
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_fwd_cnt
`endif
);

    localparam logic HzBit = (HARDWIRED_ZERO != 0);

    stage_tag_t                          ex_q;
    stage_tag_t                          mem_q;
    stage_tag_t                          wb_q;
    logic [NUM_SRC-1:0][REG_AW-1:0]      exSrcAddr_q;
    logic [NUM_SRC-1:0]                  exSrcUsed_q;

    stage_tag_t                          idTag;
    logic [NUM_SRC-1:0][REG_AW-1:0]      idSrcAddr;

    assign idTag = '{valid: id_valid,
                     dst:   TAG_AW'(id_dst_addr),
                     wr:    id_reg_write,
                     load:  id_is_load};

    always_comb begin
        idSrcAddr = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            idSrcAddr[i] = id_src_addr[i*REG_AW +: REG_AW];
        end
    end

    // ------------------------------------------------------------------
    // Shadow tag pipeline
    // ------------------------------------------------------------------
    // A flush squashes EX even while frozen; MEM/WB still respect the hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= TAG_BUBBLE;
            mem_q       <= TAG_BUBBLE;
            wb_q        <= TAG_BUBBLE;
            exSrcAddr_q <= '0;
            exSrcUsed_q <= '0;
        end else if (pipe_flush) begin
            ex_q        <= TAG_BUBBLE;
            exSrcAddr_q <= '0;
            exSrcUsed_q <= '0;
            if (!pipe_hold) begin
                mem_q <= ex_q;
                wb_q  <= mem_q;
            end
        end else if (pipe_hold) begin
            ex_q  <= ex_q;
            mem_q <= mem_q;
            wb_q  <= wb_q;
        end else if (hazard_stall) begin
            ex_q        <= TAG_BUBBLE;
            exSrcAddr_q <= '0;
            exSrcUsed_q <= '0;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
        end else begin
            ex_q        <= idTag;
            exSrcAddr_q <= idSrcAddr;
            exSrcUsed_q <= id_src_used;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-operand forwarding selects
    // ------------------------------------------------------------------
    for (genvar i = 0; i < int'(NUM_SRC); i++) begin : gen_src
        fwd_src_sel #(
            .REG_AW         (REG_AW),
            .HARDWIRED_ZERO (HARDWIRED_ZERO)
        ) u_src_sel (
            .srcAddr_i (exSrcAddr_q[i]),
            .srcUsed_i (exSrcUsed_q[i]),
            .exValid_i (ex_q.valid),
            .memTag_i  (mem_q),
            .wbTag_i   (wb_q),
            .sel_o     (fwd_sel[2*i +: 2])
        );
    end

    // ------------------------------------------------------------------
    // Load-use stall
    // ------------------------------------------------------------------
    logic exLoadLive;
    logic loadUseHit;

    // A load in EX only hazards if its result is a real register write.
    assign exLoadLive = ex_q.valid && ex_q.load && ex_q.wr && !isZeroReg(ex_q.dst, HzBit);

    always_comb begin
        loadUseHit = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (id_src_used[i] && (TAG_AW'(idSrcAddr[i]) == ex_q.dst)) begin
                loadUseHit = 1'b1;
            end
        end
    end

    // Level signal: stays high through a hold; the bubble is only inserted on
    // the first un-held edge, after which EX no longer holds the load.
    assign hazard_stall = id_valid && !pipe_flush && exLoadLive && loadUseHit;

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef FWD_PERF_CNT_EN
    logic [31:0] stallCnt_q;
    logic [31:0] fwdCnt_q;
    logic        anyFwd;

    assign anyFwd = |fwd_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
            fwdCnt_q   <= '0;
        end else if (!pipe_hold) begin
            if (hazard_stall && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
            if (anyFwd && (fwdCnt_q != '1)) begin
                fwdCnt_q <= fwdCnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stallCnt_q;
    assign perf_fwd_cnt   = fwdCnt_q;
`else
    // No counters in this build.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Directed vectors for fwd_hazard_unit. Two instances share stimulus: one with
// the zero register hardwired (default) and one without.
// ----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [9:0] id_src_addr;
    logic [1:0] id_src_used;
    logic [4:0] id_dst_addr;
    logic       id_reg_write;
    logic       id_is_load;
    logic       pipe_hold;
    logic       pipe_flush;

    logic       hazard_stall;
    logic [3:0] fwd_sel;
    logic       nzStall;
    logic [3:0] nzFwd;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] perfStall;
    logic [31:0] perfFwd;
    logic [31:0] nzPerfStall;
    logic [31:0] nzPerfFwd;
`endif

    int nVec;
    int nMiss;

    fwd_hazard_unit #(
        .NUM_SRC        (2),
        .REG_AW         (5),
        .HARDWIRED_ZERO (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src_addr  (id_src_addr),
        .id_src_used  (id_src_used),
        .id_dst_addr  (id_dst_addr),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .pipe_hold    (pipe_hold),
        .pipe_flush   (pipe_flush),
        .hazard_stall (hazard_stall),
        .fwd_sel      (fwd_sel)
`ifdef FWD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perfStall),
        .perf_fwd_cnt   (perfFwd)
`endif
    );

    fwd_hazard_unit #(
        .NUM_SRC        (2),
        .REG_AW         (5),
        .HARDWIRED_ZERO (0)
    ) dutNz (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src_addr  (id_src_addr),
        .id_src_used  (id_src_used),
        .id_dst_addr  (id_dst_addr),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .pipe_hold    (pipe_hold),
        .pipe_flush   (pipe_flush),
        .hazard_stall (nzStall),
        .fwd_sel      (nzFwd)
`ifdef FWD_PERF_CNT_EN
        ,
        .perf_stall_cnt (nzPerfStall),
        .perf_fwd_cnt   (nzPerfFwd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v,
                         input logic [4:0] s0, input logic u0,
                         input logic [4:0] s1, input logic u1,
                         input logic [4:0] d, input logic w, input logic ld);
        id_valid     = v;
        id_src_addr  = {s1, s0};
        id_src_used  = {u1, u0};
        id_dst_addr  = d;
        id_reg_write = w;
        id_is_load   = ld;
        #1;
    endtask

    task automatic drain();
        setId(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        nVec       = 0;
        nMiss      = 0;
        rst_n      = 1'b0;
        pipe_hold  = 1'b0;
        pipe_flush = 1'b0;

        // Reset with a would-be load-use pattern in ID
        setId(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
        checkVal("rst_fwd", 32'(fwd_sel), 32'h0);
        checkVal("rst_stall", 32'(hazard_stall), 32'h0);
        checkVal("rst_nz_stall", 32'(nzStall), 32'h0);
        tick();
        checkVal("rst_fwd_held", 32'(fwd_sel), 32'h0);
        checkVal("rst_stall_held", 32'(hazard_stall), 32'h0);

        // Release; add r3,r1,r2 then sub r5,r3,r3
        rst_n = 1'b1;
        setId(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        checkVal("post_rst_fwd", 32'(fwd_sel), 32'h0);
        setId(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
        checkVal("alu_no_stall", 32'(hazard_stall), 32'h0);
        tick();
        checkVal("b2b_mem", 32'(fwd_sel), 32'ha);

        // add r3; independent; consumer of r3 (operand 1 names r3 but is unused)
        drain();
        setId(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        checkVal("indep_none", 32'(fwd_sel), 32'h0);
        setId(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd11, 1'b1, 1'b0);
        tick();
        checkVal("wb_fwd_unused", 32'(fwd_sel), 32'h1);

        // MEM beats WB: two writers of r7 then a reader
        drain();
        setId(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd12, 1'b1, 1'b0);
        tick();
        checkVal("mem_over_wb", 32'(fwd_sel), 32'ha);

        // Producer without reg_write never forwards
        drain();
        setId(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0);
        tick();
        setId(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd13, 1'b1, 1'b0);
        tick();
        checkVal("no_wr_fwd", 32'(fwd_sel), 32'h0);

        // Load-use: lw r4,(r1) then add r6,r4,r1
        drain();
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        checkVal("lu_stall", 32'(hazard_stall), 32'h1);
        tick();
        checkVal("lu_once", 32'(hazard_stall), 32'h0);
        checkVal("lu_bubble", 32'(fwd_sel), 32'h0);
        tick();
        checkVal("lu_wb", 32'(fwd_sel), 32'h1);
`ifdef FWD_PERF_CNT_EN
        checkVal("lu_perf", perfStall, 32'd1);
`endif

        // Zero register: lw r0 then add r2,r0,r0
        drain();
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);
        checkVal("hz_stall", 32'(hazard_stall), 32'h0);
        checkVal("nz_stall", 32'(nzStall), 32'h1);
        tick();
        checkVal("hz_fwd_a", 32'(fwd_sel), 32'h0);
        checkVal("nz_bubble", 32'(nzFwd), 32'h0);
        checkVal("nz_stall_once", 32'(nzStall), 32'h0);
        tick();
        checkVal("hz_fwd_b", 32'(fwd_sel), 32'h0);
        checkVal("nz_wb", 32'(nzFwd), 32'h5);

        // Flush on top of a load-use condition
        drain();
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        pipe_flush = 1'b1;
        #1;
        checkVal("fl_stall", 32'(hazard_stall), 32'h0);
        tick();
        pipe_flush = 1'b0;
        #1;
        checkVal("fl_bubble", 32'(fwd_sel), 32'h0);
        checkVal("fl_nostall", 32'(hazard_stall), 32'h0);

        // Hold with a pending stall: addi r1; lw r4,(r1); add r6,r4,r1
        drain();
        setId(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        checkVal("hd_pre", 32'(fwd_sel), 32'h2);
        setId(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        pipe_hold = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkVal("hd_stall", 32'(hazard_stall), 32'h1);
            checkVal("hd_tags", 32'(fwd_sel), 32'h2);
            tick();
        end
        pipe_hold = 1'b0;
        #1;
        checkVal("hd_release", 32'(hazard_stall), 32'h1);
        tick();
        checkVal("hd_resolved", 32'(hazard_stall), 32'h0);
        checkVal("hd_bubble", 32'(fwd_sel), 32'h0);
        tick();
        checkVal("hd_wb", 32'(fwd_sel), 32'h1);
`ifdef FWD_PERF_CNT_EN
        checkVal("hd_perf", perfStall, 32'd2);
`endif

        // Reset asserted mid-operation
        drain();
        setId(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        checkVal("mr_pre", 32'(fwd_sel), 32'ha);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("mr_fwd", 32'(fwd_sel), 32'h0);
`ifdef FWD_PERF_CNT_EN
        checkVal("mr_perf", perfStall, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        checkVal("mr_post", 32'(fwd_sel), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
